// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake and line outputs of the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                               tx_en;
  logic                               tx_ready;
  logic [DATA_BITS-1:0]               din;
  logic                               sout;
  logic                               busy_tx;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;

  modport master (
    output tx_en, din,
    input  tx_ready, sout, busy_tx, fifo_count
  );

  modport slave (
    input  tx_en, din,
    output tx_ready, sout, busy_tx, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO; frames go out back-to-back while
// the FIFO holds data.
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit (low) for one bit period
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | STOP_BITS stop bits (high)
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           fpga_clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0]   LAST_CYC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);
  localparam logic            ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 sout_q, sout_d;
  logic                 pop, push;
  logic                 bit_done, fifo_nonempty;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count_q;

  assign bus.tx_ready   = (count_q != FULL_CNT);
  assign bus.fifo_count = count_q;
  assign bus.sout       = sout_q;
  assign bus.busy_tx    = (state_q != S_IDLE) || fifo_nonempty;

  assign push          = bus.tx_en && bus.tx_ready;
  assign fifo_nonempty = (count_q != '0);
  assign bit_done      = (cyc_q == LAST_CYC);

  // Next state, registered line value and FIFO pop decision.
  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        sout_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = S_START;
          sout_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          sout_d  = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_q == LAST_DATA) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              sout_d  = par_q;
            end else begin
              state_d = S_STOP;
              sout_d  = 1'b1;
            end
          end else begin
            // shreg shifts on this edge, so bit 1 becomes the next LSB
            sout_d = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          sout_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done && (bit_q == LAST_STOP)) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = S_START;
            sout_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            sout_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sout_d  = 1'b1;
      end
    endcase
  end

  // FSM state and registered serial output.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
    end
  end

  // Bit timing counters, shift register and parity capture.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) || bit_done) cyc_q <= '0;
      else                                 cyc_q <= cyc_q + 1'b1;

      if (state_d != state_q) bit_q <= '0;
      else if (bit_done)      bit_q <= bit_q + 1'b1;

      if (pop) begin
        shreg_q <= mem[rd_ptr];
        par_q   <= (^mem[rd_ptr]) ^ ODD_PAR;
      end else if ((state_q == S_DATA) && bit_done) begin
        shreg_q <= shreg_q >> 1;
      end
    end
  end

  // FIFO pointers and occupancy; a push while full never reaches here.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge fpga_clk) begin
    if (!rst && push) mem[wr_ptr] <= bus.din;
  end

endmodule
